// File: rtl/bit_counter_if.sv
// Operand/result handshake between the switch-driven controller and the bit counter.
// The master drives start and the operand; the slave returns the count and done flag.
interface bit_counter_if #(
  parameter int WIDTH = 8
);
  localparam int RESULT_W = $clog2(WIDTH + 1);

  logic                start;
  logic [WIDTH-1:0]    A;
  logic [RESULT_W-1:0] result;
  logic                done;

  modport master (
    output start,
    output A,
    input  result,
    input  done
  );

  modport slave (
    input  start,
    input  A,
    output result,
    output done
  );
endinterface

// File: rtl/bit_counter.sv
// Population counter: loads an operand in idle, shifts it out LSB-first while
// accumulating set bits, then holds the count for the HEX display until start drops.
module bit_counter #(
  parameter int WIDTH    = 8,
  parameter int RESULT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  bit_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    shreg;
  logic [RESULT_W-1:0] result;

  // Counting stops as soon as the remaining operand is zero, so latency tracks the highest set bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      shreg  <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          shreg  <= bus.A;
          result <= '0;
          if (bus.start) begin
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (shreg == '0) begin
            state <= S_DONE;
          end else begin
            result <= result + RESULT_W'(shreg[0]);
            shreg  <= shreg >> 1;
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.result = result;
  assign bus.done   = (state == S_DONE);

endmodule
